// File: rtl/serial_gen_pkg.sv
// serial_gen_pkg: shared word type, SERDES ratio and FSM states for the serial word generator
package serial_gen_pkg;
  localparam int SERDES_RATIO = 8;
  typedef logic [SERDES_RATIO-1:0] word_t;
  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
endpackage

// File: rtl/word_edge_count.sv
// word_edge_count: number of 0->1 transitions inside one serial word, seeded by the previous word's last bit
module word_edge_count
  import serial_gen_pkg::*;
(
  input  word_t      word_i,
  input  logic       prev_i,
  output logic [2:0] count_o
);
  word_t rise;
  assign rise = word_i & ~{word_i[SERDES_RATIO-2:0], prev_i};
  always_comb begin
    count_o = '0;
    for (int k = 0; k < SERDES_RATIO; k++) count_o = count_o + {2'b0, rise[k]};
  end
endmodule

// File: rtl/serial_word_gen.sv
// serial_word_gen: NCO square wave packed into 8-slot parallel words for an output serializer, with rising-edge counter
module serial_word_gen
  import serial_gen_pkg::*;
#(
  parameter int PHASE_BITS = 32,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  en_i,
  input  logic [PHASE_BITS-1:0] freq_i,
  input  logic                  freq_valid_i,
  output logic                  freq_ready_o,
  output word_t                 out_o,
  output logic                  out_valid_o,
  input  logic                  cnt_clr_i,
  output logic [CNT_BITS-1:0]   edge_count_o
);
  typedef logic [PHASE_BITS-1:0] ph_t;
  state_t state_q, state_d;
  ph_t freq_q, freq_d, pend_q, pend_d, phase_q, phase_d;
  ph_t off [SERDES_RATIO];
  logic pend_v_q, pend_v_d, last_q, last_d, valid_d, run, accept, transfer;
  word_t word, out_d;
  logic [2:0] rise_n;
  logic [CNT_BITS:0] cnt_sum;
  logic [CNT_BITS-1:0] cnt_d;
  // slot offsets k*freq built from shifts and adds
  assign off[0] = '0;
  assign off[1] = freq_q;
  assign off[2] = freq_q << 1;
  assign off[3] = off[2] + freq_q;
  assign off[4] = freq_q << 2;
  assign off[5] = off[4] + freq_q;
  assign off[6] = off[4] + off[2];
  assign off[7] = off[4] + off[3];
  for (genvar k = 0; k < SERDES_RATIO; k++) begin : g_slot
    ph_t s;
    assign s = phase_q + off[k];
    assign word[k] = s[PHASE_BITS-1];
  end
  word_edge_count u_edges (
    .word_i  (word),
    .prev_i  (last_q),
    .count_o (rise_n)
  );
  assign run          = state_q == RUN;
  assign freq_ready_o = !pend_v_q && resetn_i;
  assign accept       = freq_valid_i && freq_ready_o;
  assign transfer     = state_q != IDLE && pend_v_q;
  assign cnt_sum      = {1'b0, edge_count_o} + {{(CNT_BITS-2){1'b0}}, rise_n};
  always_comb begin
    state_d  = !en_i ? IDLE : state_q == IDLE ? START : RUN;
    out_d    = run ? word : '0;
    valid_d  = run;
    phase_d  = run ? phase_q + (freq_q << 3) : '0;
    last_d   = run & word[SERDES_RATIO-1];
    freq_d   = transfer ? pend_q : freq_q;
    pend_d   = accept ? freq_i : pend_q;
    pend_v_d = accept | (pend_v_q & !transfer);
    cnt_d    = cnt_clr_i ? '0 : !run ? edge_count_o : cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      freq_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      phase_q      <= '0;
      last_q       <= 1'b0;
      out_o        <= '0;
      out_valid_o  <= 1'b0;
      edge_count_o <= '0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      phase_q      <= phase_d;
      last_q       <= last_d;
      out_o        <= out_d;
      out_valid_o  <= valid_d;
      edge_count_o <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_word_gen.sv
// tb_serial_word_gen: directed stimulus with a slot-level reference model and per-cycle output comparison
module tb_serial_word_gen;
  logic clk = 1'b0;
  logic resetn_i, en_i, freq_valid_i, freq_ready_o, out_valid_o, cnt_clr_i;
  logic [31:0] freq_i;
  logic [7:0] out_o;
  logic [15:0] edge_count_o;
  int checks = 0, errors = 0;

  serial_word_gen dut (
    .clk_i        (clk),
    .resetn_i     (resetn_i),
    .en_i         (en_i),
    .freq_i       (freq_i),
    .freq_valid_i (freq_valid_i),
    .freq_ready_o (freq_ready_o),
    .out_o        (out_o),
    .out_valid_o  (out_valid_o),
    .cnt_clr_i    (cnt_clr_i),
    .edge_count_o (edge_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] slots(input logic [31:0] ph, input logic [31:0] f);
    logic [7:0] w;
    logic [31:0] s;
    for (int k = 0; k < 8; k++) begin
      s = ph + 32'(k) * f;
      w[k] = s[31];
    end
    return w;
  endfunction

  function automatic int rises(input logic [7:0] w, input logic prev);
    int n = 0;
    logic p = prev;
    for (int k = 0; k < 8; k++) begin
      if (w[k] && !p) n++;
      p = w[k];
    end
    return n;
  endfunction

  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2;
  int m_mode, e_cnt;
  logic [31:0] m_freq, m_pend, m_phase;
  logic m_pend_v, m_last, e_valid, acc, m_started = 1'b0;
  logic [7:0] e_out;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!resetn_i) begin
      m_mode = M_IDLE; m_freq = 0; m_pend = 0; m_pend_v = 0; m_phase = 0; m_last = 0;
      e_out = 0; e_valid = 0; e_cnt = 0;
    end else begin
      acc = freq_valid_i && !m_pend_v;
      if (m_mode == M_RUN) begin
        e_out = slots(m_phase, m_freq);
        e_valid = 1;
        e_cnt = e_cnt + rises(e_out, m_last);
        if (e_cnt > 65535) e_cnt = 65535;
        m_last = e_out[7];
        m_phase = m_phase + 32'd8 * m_freq;
      end else begin
        e_out = 0; e_valid = 0; m_phase = 0; m_last = 0;
      end
      if (cnt_clr_i) e_cnt = 0;
      if (m_mode != M_IDLE && m_pend_v) begin
        m_freq = m_pend;
        m_pend_v = 0;
      end
      if (acc) begin
        m_pend = freq_i;
        m_pend_v = 1;
      end
      m_mode = !en_i ? M_IDLE : (m_mode == M_IDLE ? M_START : M_RUN);
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_started) begin
      chk("cyc_out", out_o, e_out);
      chk("cyc_valid", out_valid_o, e_valid);
      chk("cyc_cnt", edge_count_o, e_cnt);
      chk("cyc_ready", freq_ready_o, !m_pend_v && resetn_i);
    end
  end

  task automatic load_freq(input logic [31:0] f);
    int n = 0;
    @(negedge clk);
    while (!freq_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", n < 20, 1);
    freq_i = f;
    freq_valid_i = 1;
    @(negedge clk);
    freq_valid_i = 0;
  endtask

  task automatic clear_cnt();
    cnt_clr_i = 1;
    @(negedge clk);
    cnt_clr_i = 0;
    chk("clr_zero", edge_count_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  logic [7:0] seg[$];
  logic bits[$];
  int run_len, min_run;
  bit first_run;

  initial begin
    resetn_i = 0; en_i = 0; freq_i = 0; freq_valid_i = 0; cnt_clr_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_out", out_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_cnt", edge_count_o, 0);
    chk("rst_ready", freq_ready_o, 0);
    resetn_i = 1;
    load_freq(32'h2000_0000);
    en_i = 1;
    @(negedge clk); chk("start_valid_a", out_valid_o, 0);
    @(negedge clk); chk("start_valid_b", out_valid_o, 0);
    @(negedge clk);
    chk("first_word", out_o, 8'hF0);
    chk("first_valid", out_valid_o, 1);
    chk("first_cnt", edge_count_o, 1);
    repeat (99) @(negedge clk);
    chk("cnt_100", edge_count_o, 100);
    chk("f29_word", out_o, 8'hF0);

    load_freq(32'h4000_0000);
    repeat (3) @(negedge clk);
    clear_cnt();
    repeat (10) @(negedge clk);
    chk("f30_word", out_o, 8'hCC);
    chk("f30_cnt", edge_count_o, 20);

    load_freq(32'h8000_0000);
    repeat (3) @(negedge clk);
    clear_cnt();
    repeat (10) @(negedge clk);
    chk("f31_word", out_o, 8'hAA);
    chk("f31_cnt", edge_count_o, 40);

    load_freq(32'h4000_0000);
    repeat (4) @(negedge clk);
    seg = {};
    seg.push_back(out_o);
    chk("pre_switch_ready", freq_ready_o, 1);
    freq_i = 32'h2000_0000;
    freq_valid_i = 1;
    @(negedge clk); freq_valid_i = 0; seg.push_back(out_o);
    chk("switch_ready_low", freq_ready_o, 0);
    chk("switch_old_a", out_o, 8'hCC);
    @(negedge clk); seg.push_back(out_o);
    chk("switch_ready_back", freq_ready_o, 1);
    chk("switch_old_b", out_o, 8'hCC);
    @(negedge clk); seg.push_back(out_o);
    chk("switch_new", out_o, 8'hF0);
    repeat (2) begin @(negedge clk); seg.push_back(out_o); end
    bits = {};
    foreach (seg[i]) for (int k = 0; k < 8; k++) bits.push_back(seg[i][k]);
    run_len = 1; min_run = 99; first_run = 1;
    for (int i = 1; i < bits.size(); i++) begin
      if (bits[i] == bits[i-1]) run_len++;
      else begin
        if (!first_run && run_len < min_run) min_run = run_len;
        first_run = 0;
        run_len = 1;
      end
    end
    chk("glitch_free", min_run >= 2, 1);

    load_freq(32'h0);
    repeat (4) @(negedge clk);
    clear_cnt();
    repeat (10) @(negedge clk);
    chk("f0_word", out_o, 8'h00);
    chk("f0_valid", out_valid_o, 1);
    chk("f0_cnt", edge_count_o, 0);

    load_freq(32'h8000_0000);
    repeat (3) @(negedge clk);
    clear_cnt();
    repeat (16400) @(negedge clk);
    chk("sat_cnt", edge_count_o, 16'hFFFF);
    chk("sat_word", out_o, 8'hAA);
    clear_cnt();
    @(negedge clk);
    chk("after_clr_cnt", edge_count_o, 4);

    load_freq(32'h3000_0000);
    repeat (5) @(negedge clk);
    en_i = 0;
    @(negedge clk); chk("en_off_last_valid", out_valid_o, 1);
    @(negedge clk);
    chk("en_off_valid", out_valid_o, 0);
    chk("en_off_out", out_o, 0);
    en_i = 1;
    @(negedge clk); chk("restart_a", out_valid_o, 0);
    @(negedge clk); chk("restart_b", out_valid_o, 0);
    @(negedge clk);
    chk("restart_word0", out_o, 8'h38);
    chk("restart_valid", out_valid_o, 1);
    @(negedge clk); chk("restart_word1", out_o, 8'hC7);

    repeat (3) @(negedge clk);
    resetn_i = 0;
    #1 chk("midrst_ready", freq_ready_o, 0);
    @(negedge clk);
    chk("midrst_out", out_o, 0);
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_cnt", edge_count_o, 0);
    resetn_i = 1;
    repeat (4) @(negedge clk);
    chk("postrst_out", out_o, 0);
    chk("postrst_valid", out_valid_o, 1);
    load_freq(32'h2000_0000);
    repeat (3) @(negedge clk);
    chk("reload_word", out_o, 8'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_gen.md
# serial_word_gen

Parallel-word square-wave generator for the sensor output path, the transmit counterpart of the 8:1 DDR input deserializer. Each CLK cycle it emits one 8-bit word holding the next 8 serial bit-slots of a square wave set by an NCO frequency word. The word feeds a downstream 8:1 output serializer (OSERDES-style): bit 0 is shifted out first, bit 7 last. A running rising-edge counter lets a loopback bench check the deserialized stream against it.

## Interface
- PHASE_BITS, 32, phase accumulator and frequency word width
- CNT_BITS, 16, width of rising-edge counter (saturating)
- CLK  in  1  parallel-word clock (200 MHz in system); only clock
- RESETN  in  1  synchronous, active-low reset
- EN  in  1  generator enable; level-sensitive
- FREQ_IN  in  PHASE_BITS  phase increment per serial bit-slot (cycles-per-bit × 2^PHASE_BITS)
- FREQ_VALID  in  1  FREQ_IN offered
- FREQ_READY  out  1  FREQ_IN accepted when VALID&READY at a rising CLK
- OUT  out  8  serial word; bit k = slot k, bit 0 earliest
- OUT_VALID  out  1  OUT carries generated data
- CNT_CLR  in  1  clear edge counter
- EDGE_COUNT  out  CNT_BITS  number of 0→1 transitions emitted since last clear

## Operation
- Registers: freq_r, pend_r + pend_v (pending frequency), phase_r, last_bit_r (previous word's bit 7), state.
- FSM states: IDLE, START, RUN.
  - IDLE: OUT=0, OUT_VALID=0, phase_r=0, last_bit_r=0. EN=1 → START.
  - START: one cycle; phase_r held 0; pending frequency applied; OUT_VALID stays 0. EN=1 → RUN, EN=0 → IDLE.
  - RUN: each cycle OUT ← {MSB(phase_r + k·freq_r) for k=7..0}, sums mod 2^PHASE_BITS; phase_r ← phase_r + 8·freq_r (wraps); OUT_VALID ← 1; last_bit_r ← new bit 7. EN=0 → IDLE; OUT and OUT_VALID go to 0 next cycle.
- Frequency handshake: FREQ_READY = !pend_v && RESETN. Accept → pend_r=FREQ_IN, pend_v=1. In START or RUN, pend_v=1 transfers pend_r→freq_r and clears pend_v in the same edge. The word computed at that edge still uses the old freq_r. In IDLE, pend_v stays 1 until START. So FREQ_READY is low for exactly one cycle after an accept while running.
- Edge counter: rising edges per word = count of k in 0..7 with bit k=1 and bit k−1=0, where bit −1 = last_bit_r. Per-word value is 0..4. EDGE_COUNT adds it each RUN word and saturates at 2^CNT_BITS−1. CNT_CLR=1 sets the counter to 0 and discards that cycle's increment. The counter holds its value in IDLE/START.
- last_bit_r is 0 at the first RUN word, so a word starting with 1 counts an edge at slot 0.
- freq_r=0 gives constant OUT=0. freq_r ≥ 2^(PHASE_BITS−1) aliases, and this is legal; no clamping.

## Timing
- Reset (RESETN=0 at an edge): state=IDLE, OUT=0, OUT_VALID=0, FREQ_READY=0 while RESETN low, EDGE_COUNT=0, freq_r=0, pend_v=0, phase_r=0. Reset mid-RUN aborts with no partial word.
- EN rises, sampled at edge t → START at t+1 → first OUT_VALID=1 word at t+2.
- FREQ accepted at edge t in RUN: pend applied at t+1. The first word using the new frequency appears at t+2, phase-continuous (phase_r is not reset).
- EN falls, sampled at edge t: the word registered at t is still valid; OUT=0 and OUT_VALID=0 after t+1.
- OUT, OUT_VALID and EDGE_COUNT are all registered, with no combinational input→output path except FREQ_READY←RESETN.

## Structure
- Package serial_gen_pkg: SERDES_RATIO=8, typedef word_t (logic [7:0]), state enum {IDLE, START, RUN}.
- Sub-module word_edge_count: combinational popcount of rising edges given (word, prev_bit), returns 3 bits.
- Phase offsets k·freq_r are built from shifts/adds (k=0..7), with no multipliers.

## Test plan
- Reset, FREQ_IN=2^29 accepted, EN=1 → from t+2 OUT=0xF0 every cycle, EDGE_COUNT +1 per word (100 words → 100).
- FREQ_IN=2^30 → OUT=0xCC steady, +2 edges/word. FREQ_IN=2^31 → OUT=0xAA, +4/word.
- Running at 2^30, offer 2^29 mid-stream → FREQ_READY low one cycle. One more 0xCC word, then phase-continuous 2^29 pattern. No glitch: every run length ≥ 2 slots, checked via serialized stream.
- FREQ_IN=0, EN=1 → OUT=0x00, OUT_VALID=1, EDGE_COUNT unchanged. Preload EDGE_COUNT near max with 2^31 → saturates at 0xFFFF. CNT_CLR → 0.
- EN toggled off/on → OUT_VALID drops one cycle after EN sampled low. Restart passes through START with phase 0, and the first word is identical to the post-reset first word.
- RESETN pulsed low mid-RUN → next cycle OUT=0, OUT_VALID=0, EDGE_COUNT=0, FREQ_READY=0 while low. freq_r returns to 0, so a new frequency must be reloaded.
